// File: rtl/oled_i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : oled_i2c_pkg
//  Description : Shared types and constants for the SSD1306-style I2C
//                write responder: FSM state encoding, default slave
//                address, SSD1306 control-byte values and the helper that
//                decides whether a bus condition cut a byte short.
//  Revision    : 1.0 - initial release
// ============================================================================
package oled_i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ADDR     = 3'd1,
      ST_ADDR_ACK = 3'd2,
      ST_CTRL     = 3'd3,
      ST_CTRL_ACK = 3'd4,
      ST_DATA     = 3'd5,
      ST_DATA_ACK = 3'd6,
      ST_IGNORE   = 3'd7
   } state_t;

   localparam logic [6:0] OLED_ADDR_DEF    = 7'h3C;

   // SSD1306 control bytes: bit7 = Co (continuation), bit6 = D/C#
   localparam logic [7:0] CTRL_CMD_STREAM  = 8'h00;
   localparam logic [7:0] CTRL_DATA_STREAM = 8'h40;
   localparam logic [7:0] CTRL_CMD_SINGLE  = 8'h80;
   localparam logic [7:0] CTRL_DATA_SINGLE = 8'hC0;

   // A STOP or repeated START is always preceded by one SCL rising edge
   // that belongs to no real bit (the master raises SCL, then moves SDA).
   // That lone unfinished clock (count 1, clock still open) is not a
   // partial byte; any other non-zero count is.
   function automatic logic partial_byte(input logic [2:0] bit_cnt,
                                         input logic       clk_open);
      return (bit_cnt != 3'd0) && !((bit_cnt == 3'd1) && clk_open);
   endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_cond_detect.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_cond_detect
//  Description : Synchronises SCL/SDA into the clk domain, keeps one
//                edge-detect flop per line and produces registered
//                one-cycle pulses for START, STOP, SCL rise and SCL fall.
//                Input-to-pulse latency is SYNC_STAGES+1 cycles.
//  Ports       : clk, rst_n     - clock, async active-low reset
//                i_scl, i_sda   - raw bus lines
//                o_start/o_stop - bus condition pulses
//                o_scl_rise/o_scl_fall - SCL edge pulses
//                o_sda_smp      - synced SDA aligned with the edge pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_cond_detect #(
   parameter int SYNC_STAGES = 2        // must be >= 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_scl,
   input  logic i_sda,
   output logic o_start,
   output logic o_stop,
   output logic o_scl_rise,
   output logic o_scl_fall,
   output logic o_sda_smp
);

   logic [SYNC_STAGES-1:0] r_scl_sync;
   logic [SYNC_STAGES-1:0] r_sda_sync;
   logic                   r_scl_d;
   logic                   r_sda_d;
   logic                   r_start;
   logic                   r_stop;
   logic                   r_scl_rise;
   logic                   r_scl_fall;
   logic                   r_sda_smp;

   logic                   w_scl;
   logic                   w_sda;

   assign w_scl = r_scl_sync[SYNC_STAGES-1];
   assign w_sda = r_sda_sync[SYNC_STAGES-1];

   // Everything resets to the idle-bus level (high) so that leaving reset
   // with the bus idle produces no spurious edges or conditions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl_d    <= 1'b1;
         r_sda_d    <= 1'b1;
         r_start    <= 1'b0;
         r_stop     <= 1'b0;
         r_scl_rise <= 1'b0;
         r_scl_fall <= 1'b0;
         r_sda_smp  <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
         r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
         r_scl_d    <= w_scl;
         r_sda_d    <= w_sda;
         // SCL must be high on both sides of the SDA edge
         r_start    <= w_scl & r_scl_d &  r_sda_d & ~w_sda;
         r_stop     <= w_scl & r_scl_d & ~r_sda_d &  w_sda;
         r_scl_rise <=  w_scl & ~r_scl_d;
         r_scl_fall <= ~w_scl &  r_scl_d;
         r_sda_smp  <= w_sda;
      end
   end

   assign o_start    = r_start;
   assign o_stop     = r_stop;
   assign o_scl_rise = r_scl_rise;
   assign o_scl_fall = r_scl_fall;
   assign o_sda_smp  = r_sda_smp;

endmodule
`default_nettype wire

// File: rtl/oled_i2c_responder.sv
`default_nettype none
// ============================================================================
//  Module      : oled_i2c_responder
//  Description : Write-only I2C responder modelling the SSD1306 side of the
//                OLED link. Matches the slave address, ACKs by pulling SDA
//                low, decodes SSD1306 control bytes and strobes out every
//                command/data payload byte.
//  Ports       : CLOCK, RST_n       - clock, async active-low reset
//                OLED_SCL, OLED_SDA - bus lines (SDA = resolved wire level)
//                SDA_OE             - 1 = pull SDA low
//                RX_DATA, RX_DC     - last payload byte and its type
//                RX_VALID           - one-cycle payload strobe
//                BUS_BUSY           - high from START until STOP
//                ERR                - one-cycle strobe on a truncated byte
//  Revision    : 1.0 - initial release
// ============================================================================
module oled_i2c_responder
   import oled_i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR  = OLED_ADDR_DEF,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       CLOCK,
   input  logic       RST_n,
   input  logic       OLED_SCL,
   input  logic       OLED_SDA,
   output logic       SDA_OE,
   output logic [7:0] RX_DATA,
   output logic       RX_DC,
   output logic       RX_VALID,
   output logic       BUS_BUSY,
   output logic       ERR
);

   logic       w_start;
   logic       w_stop;
   logic       w_rise;
   logic       w_fall;
   logic       w_sda;
   logic [7:0] w_byte;
   logic       w_partial;

   state_t     r_state;
   logic [2:0] r_bit_cnt;
   logic [6:0] r_shift;
   logic       r_clk_open;     // SCL rise seen for the current bit, fall not yet
   logic       r_co;
   logic       r_dc;
   logic       r_sda_oe;
   logic [7:0] r_rx_data;
   logic       r_rx_dc;
   logic       r_rx_valid;
   logic       r_bus_busy;
   logic       r_err;

   i2c_cond_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_cond (
      .clk        (CLOCK),
      .rst_n      (RST_n),
      .i_scl      (OLED_SCL),
      .i_sda      (OLED_SDA),
      .o_start    (w_start),
      .o_stop     (w_stop),
      .o_scl_rise (w_rise),
      .o_scl_fall (w_fall),
      .o_sda_smp  (w_sda)
   );

   assign w_byte    = {r_shift, w_sda};
   assign w_partial = partial_byte(r_bit_cnt, r_clk_open);

   always_ff @(posedge CLOCK or negedge RST_n) begin
      if (!RST_n) begin
         r_state    <= ST_IDLE;
         r_bit_cnt  <= 3'd0;
         r_shift    <= 7'd0;
         r_clk_open <= 1'b0;
         r_co       <= 1'b0;
         r_dc       <= 1'b0;
         r_sda_oe   <= 1'b0;
         r_rx_data  <= 8'd0;
         r_rx_dc    <= 1'b0;
         r_rx_valid <= 1'b0;
         r_bus_busy <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         r_err      <= 1'b0;

         if (w_start) begin
            r_err      <= w_partial;
            r_state    <= ST_ADDR;
            r_bit_cnt  <= 3'd0;
            r_clk_open <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_bus_busy <= 1'b1;
         end else if (w_stop) begin
            r_err      <= w_partial;
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 3'd0;
            r_clk_open <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_bus_busy <= 1'b0;
         end else begin
            if (w_fall) begin
               r_clk_open <= 1'b0;
            end

            case (r_state)
               ST_ADDR, ST_CTRL, ST_DATA: begin
                  if (w_rise) begin
                     r_shift <= w_byte[6:0];
                     if (r_bit_cnt == 3'd7) begin
                        r_bit_cnt <= 3'd0;
                        case (r_state)
                           ST_ADDR: begin
                              if ((w_byte[7:1] == SLAVE_ADDR) && !w_byte[0]) begin
                                 r_state <= ST_ADDR_ACK;
                              end else begin
                                 r_state <= ST_IGNORE;
                              end
                           end
                           ST_CTRL: begin
                              r_co    <= w_byte[7];
                              r_dc    <= w_byte[6];
                              r_state <= ST_CTRL_ACK;
                           end
                           default: begin
                              r_rx_data  <= w_byte;
                              r_rx_dc    <= r_dc;
                              r_rx_valid <= 1'b1;
                              r_state    <= ST_DATA_ACK;
                           end
                        endcase
                     end else begin
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        r_clk_open <= 1'b1;
                     end
                  end
               end

               // First SCL fall (end of bit 8) grabs SDA, the next one
               // (end of the ninth clock) releases it and moves on.
               ST_ADDR_ACK, ST_CTRL_ACK, ST_DATA_ACK: begin
                  if (w_fall) begin
                     if (!r_sda_oe) begin
                        r_sda_oe <= 1'b1;
                     end else begin
                        r_sda_oe <= 1'b0;
                        case (r_state)
                           ST_ADDR_ACK: r_state <= ST_CTRL;
                           ST_CTRL_ACK: r_state <= ST_DATA;
                           default:     r_state <= r_co ? ST_CTRL : ST_DATA;
                        endcase
                     end
                  end
               end

               default: begin
                  // IDLE and IGNORE only react to START/STOP
                  r_sda_oe <= 1'b0;
               end
            endcase
         end
      end
   end

   assign SDA_OE   = r_sda_oe;
   assign RX_DATA  = r_rx_data;
   assign RX_DC    = r_rx_dc;
   assign RX_VALID = r_rx_valid;
   assign BUS_BUSY = r_bus_busy;
   assign ERR      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_oled_i2c_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_oled_i2c_responder
//  Description : Self-checking bench for oled_i2c_responder. A bit-banged
//                I2C master drives the bus through an open-drain model;
//                expected payload bytes are queued as they are sent and
//                compared when RX_VALID fires.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_oled_i2c_responder;
   import oled_i2c_pkg::*;

   localparam int c_half = 6;          // CLOCK cycles per SCL phase

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       m_scl = 1'b1;
   logic       m_sda = 1'b1;
   logic       w_sda_line;
   logic       sda_oe;
   logic [7:0] rx_data;
   logic       rx_dc;
   logic       rx_valid;
   logic       bus_busy;
   logic       err;

   logic [8:0] q_exp[$];               // {dc, data}
   int         n_vec  = 0;
   int         n_miss = 0;
   int         n_ack  = 0;
   int         n_rx   = 0;
   int         n_err  = 0;
   int         a0, r0, e0;
   logic       oe_prev = 1'b0;

   assign w_sda_line = m_sda & ~sda_oe;

   always #5 clk = ~clk;

   oled_i2c_responder #(
      .SLAVE_ADDR  (OLED_ADDR_DEF),
      .SYNC_STAGES (2)
   ) dut (
      .CLOCK    (clk),
      .RST_n    (rst_n),
      .OLED_SCL (m_scl),
      .OLED_SDA (w_sda_line),
      .SDA_OE   (sda_oe),
      .RX_DATA  (rx_data),
      .RX_DC    (rx_dc),
      .RX_VALID (rx_valid),
      .BUS_BUSY (bus_busy),
      .ERR      (err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Output monitor / scoreboard
   always @(negedge clk) begin
      if (sda_oe && !oe_prev) n_ack++;
      oe_prev = sda_oe;
      if (err) n_err++;
      if (rx_valid) begin
         n_rx++;
         if (q_exp.size() == 0) begin
            check("rx_unexpected", {31'd0, rx_valid}, 32'd0);
         end else begin
            logic [8:0] exp;
            exp = q_exp.pop_front();
            check("rx_byte", {23'd0, rx_dc, rx_data}, {23'd0, exp});
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic i2c_start;
      m_sda = 1'b1; wait_clk(c_half);
      m_scl = 1'b1; wait_clk(c_half);
      m_sda = 1'b0; wait_clk(c_half);
      m_scl = 1'b0; wait_clk(2);
   endtask

   task automatic i2c_stop;
      m_sda = 1'b0; wait_clk(c_half);
      m_scl = 1'b1; wait_clk(c_half);
      m_sda = 1'b1; wait_clk(c_half);
   endtask

   task automatic i2c_bit(input logic b);
      m_sda = b;    wait_clk(c_half);
      m_scl = 1'b1; wait_clk(c_half);
      m_scl = 1'b0; wait_clk(2);
   endtask

   // Eight data bits, then a ninth clock with SDA released; the wire
   // level mid-high shows whether the responder ACKed.
   task automatic i2c_byte(input logic [7:0] b, input logic ack_exp, input string tag);
      for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
      m_sda = 1'b1; wait_clk(c_half);
      m_scl = 1'b1; wait_clk(c_half / 2);
      #1 check(tag, {31'd0, w_sda_line}, ack_exp ? 32'd0 : 32'd1);
      wait_clk(c_half - c_half / 2);
      m_scl = 1'b0; wait_clk(2);
   endtask

   task automatic snap;
      a0 = n_ack; r0 = n_rx; e0 = n_err;
   endtask

   task automatic end_check(input string tag, input int acks, input int rxs, input int errs);
      wait_clk(8);
      #1;
      check({tag, "_acks"}, n_ack - a0, acks);
      check({tag, "_rx"},   n_rx - r0,  rxs);
      check({tag, "_err"},  n_err - e0, errs);
      check({tag, "_busy"}, {31'd0, bus_busy}, 32'd0);
      check({tag, "_qempty"}, q_exp.size(), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // Reset state
      wait_clk(4);
      #1;
      check("rst_oe",    {31'd0, sda_oe},   32'd0);
      check("rst_valid", {31'd0, rx_valid}, 32'd0);
      check("rst_busy",  {31'd0, bus_busy}, 32'd0);
      check("rst_err",   {31'd0, err},      32'd0);
      check("rst_data",  {24'd0, rx_data},  32'd0);
      check("rst_dc",    {31'd0, rx_dc},    32'd0);
      rst_n = 1'b1;
      wait_clk(5);

      // 1: command stream
      snap();
      i2c_start();
      wait_clk(4);
      #1 check("t1_busy", {31'd0, bus_busy}, 32'd1);
      i2c_byte(8'h78, 1'b1, "t1_ack_addr");
      i2c_byte(CTRL_CMD_STREAM, 1'b1, "t1_ack_ctrl");
      q_exp.push_back({1'b0, 8'hAE});
      i2c_byte(8'hAE, 1'b1, "t1_ack_d0");
      q_exp.push_back({1'b0, 8'hAF});
      i2c_byte(8'hAF, 1'b1, "t1_ack_d1");
      i2c_stop();
      end_check("t1", 4, 2, 0);
      check("t1_rx_hold", {24'd0, rx_data}, 32'hAF);

      // 2: single command then data stream
      snap();
      i2c_start();
      i2c_byte(8'h78, 1'b1, "t2_ack_addr");
      i2c_byte(CTRL_CMD_SINGLE, 1'b1, "t2_ack_c0");
      q_exp.push_back({1'b0, 8'hA4});
      i2c_byte(8'hA4, 1'b1, "t2_ack_d0");
      i2c_byte(CTRL_DATA_STREAM, 1'b1, "t2_ack_c1");
      q_exp.push_back({1'b1, 8'h55});
      i2c_byte(8'h55, 1'b1, "t2_ack_d1");
      q_exp.push_back({1'b1, 8'hAA});
      i2c_byte(8'hAA, 1'b1, "t2_ack_d2");
      i2c_stop();
      end_check("t2", 6, 3, 0);

      // 3: wrong address
      snap();
      i2c_start();
      i2c_byte(8'h7A, 1'b0, "t3_nack_addr");
      i2c_byte(8'h00, 1'b0, "t3_nack_c");
      i2c_byte(8'hAE, 1'b0, "t3_nack_d");
      i2c_stop();
      end_check("t3", 0, 0, 0);

      // 4: read address ignored, repeated START recovers
      snap();
      i2c_start();
      i2c_byte(8'h79, 1'b0, "t4_nack_read");
      i2c_start();
      i2c_byte(8'h78, 1'b1, "t4_ack_addr");
      i2c_byte(CTRL_DATA_STREAM, 1'b1, "t4_ack_ctrl");
      q_exp.push_back({1'b1, 8'h12});
      i2c_byte(8'h12, 1'b1, "t4_ack_d");
      i2c_stop();
      end_check("t4", 3, 1, 0);

      // 5: STOP after three bits of a byte
      snap();
      i2c_start();
      i2c_byte(8'h78, 1'b1, "t5_ack_addr");
      i2c_byte(CTRL_CMD_STREAM, 1'b1, "t5_ack_ctrl");
      i2c_bit(1'b1);
      i2c_bit(1'b0);
      i2c_bit(1'b1);
      i2c_stop();
      end_check("t5", 2, 0, 1);

      // 6: reset while holding the address ACK
      i2c_start();
      for (int i = 7; i >= 0; i--) i2c_bit(logic'(8'h78 >> i));
      for (int i = 0; i < 64 && !sda_oe; i++) @(negedge clk);
      check("t6_ack_seen", {31'd0, sda_oe}, 32'd1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check("t6_oe_async", {31'd0, sda_oe}, 32'd0);
      check("t6_busy_rst", {31'd0, bus_busy}, 32'd0);
      m_scl = 1'b1;
      m_sda = 1'b1;
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(5);
      snap();
      i2c_start();
      i2c_byte(8'h78, 1'b1, "t6_ack_addr");
      i2c_byte(CTRL_CMD_STREAM, 1'b1, "t6_ack_ctrl");
      q_exp.push_back({1'b0, 8'hAF});
      i2c_byte(8'hAF, 1'b1, "t6_ack_d");
      i2c_stop();
      end_check("t6", 3, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/oled_i2c_responder.md
Name: oled_i2c_responder

Overview:
- Synthesizable I2C write-only responder that models the SSD1306 end of the OLED_SCL/OLED_SDA link driven by oled_basemod.
- Oversamples SCL/SDA on CLOCK and detects START, repeated START and STOP.
- Matches the slave address, ACKs by pulling SDA low, and decodes SSD1306 control bytes.
- Emits each received command/data byte as a one-cycle strobe. Used as the bus partner in oled_basemod benches and as an on-chip bus monitor.

Parameters:
- SLAVE_ADDR, 7'h3C, 7-bit address; write address byte 0x78.
- SYNC_STAGES, 2, synchronizer flops on SCL and SDA (minimum 2).

Ports:
- CLOCK  input  1  system clock.
- RST_n  input  1  asynchronous active-low reset.
- OLED_SCL  input  1  bus clock from master.
- OLED_SDA  input  1  bus data as seen on the wire (resolved value).
- SDA_OE  output  1  1 = pull SDA low (ACK); 0 = release. Top-level drives open-drain.
- RX_DATA  output  8  last received payload byte.
- RX_DC  output  1  type of RX_DATA: 0 = command, 1 = GDDRAM data.
- RX_VALID  output  1  one-CLOCK strobe; RX_DATA/RX_DC valid in the same cycle.
- BUS_BUSY  output  1  1 from START until STOP.
- ERR  output  1  one-CLOCK strobe on STOP/START with a partial byte (bit count 1..7).

Behaviour:
- Reset: asynchronous, active-low.
  - State IDLE; bit counter 0.
  - SDA_OE, RX_DATA, RX_DC, RX_VALID, BUS_BUSY and ERR all 0.
  - Reset mid-ACK releases SDA_OE with no CLOCK edge required.
- Input path: SCL/SDA pass through SYNC_STAGES flops, then one edge-detect flop. Input-to-event latency is SYNC_STAGES+1 CLOCK cycles. The master must hold each SCL high/low phase for at least 4 CLOCK cycles.
- Bus conditions:
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
  - Both override everything except reset.
- Bit sampling: SDA sampled on synced SCL rising edge, MSB first; 3-bit counter.
- States: IDLE, ADDR, ADDR_ACK, CTRL, CTRL_ACK, DATA, DATA_ACK, IGNORE.
  - IDLE -> ADDR on START; BUS_BUSY=1.
  - ADDR: after 8 bits, byte[7:1]==SLAVE_ADDR and byte[0]==0 -> ADDR_ACK; otherwise -> IGNORE (no ACK; R/W=1 is never ACKed).
  - Every *_ACK state: SDA_OE=1 from the SCL falling edge after bit 8 until the next SCL falling edge (the 9th clock), then released.
  - ADDR_ACK -> CTRL.
  - CTRL: after 8 bits, latch Co=bit7 and DC=bit6; bits[5:0] ignored -> CTRL_ACK.
  - CTRL_ACK -> DATA.
  - DATA: after 8 bits, RX_DATA=byte, RX_DC=DC, RX_VALID pulses one cycle after the 8th sampled rising edge -> DATA_ACK.
  - DATA_ACK -> CTRL if Co=1; -> DATA if Co=0 (stream until STOP).
  - IGNORE: SDA_OE held 0; wait for START or STOP.
- START in any non-IDLE state (repeated START):
  - -> ADDR; counter cleared; SDA_OE released.
  - ERR pulses if counter in 1..7 (not during ACK clocks).
- STOP in any state:
  - -> IDLE; BUS_BUSY=0; SDA_OE released.
  - Partial byte discarded, no RX_VALID; ERR pulses if counter in 1..7.
- The master's ninth-clock SDA level is ignored; only START/STOP detection uses SDA while SCL is high.
- RX_DATA/RX_DC hold their value until the next RX_VALID.

Decomposition:
- Package oled_i2c_pkg:
  - state enum.
  - OLED_ADDR_DEF = 7'h3C.
  - SSD1306 control constants: CTRL_CMD_STREAM 8'h00, CTRL_DATA_STREAM 8'h40, CTRL_CMD_SINGLE 8'h80, CTRL_DATA_SINGLE 8'hC0.
- Sub-module i2c_cond_detect: synchronizer, edge detect, START/STOP/SCL_RISE/SCL_FALL pulse outputs. The responder FSM instantiates it once.

Test Plan:
- START, 0x78, 0x00, 0xAE, 0xAF, STOP -> SDA_OE high on 4 ninth clocks; RX_VALID ×2 with RX_DATA 0xAE then 0xAF, RX_DC=0; BUS_BUSY 0 after STOP.
- START, 0x78, 0x80, 0xA4, 0x40, 0x55, 0xAA, STOP -> RX 0xA4 with DC=0, then 0x55 and 0xAA with DC=1; 6 ACKs.
- START, 0x7A (wrong address), 0x00, 0xAE, STOP -> SDA_OE never 1, no RX_VALID, ERR 0.
- START, 0x79 (read) -> no ACK, IGNORE. Repeated START, 0x78, 0x40, 0x12 -> ACKed; RX 0x12, DC=1.
- START, 0x78, 0x00, 3 bits of a byte, STOP -> ERR one pulse, no RX_VALID, state IDLE, BUS_BUSY 0.
- RST_n low during ADDR_ACK -> SDA_OE 0 asynchronously. After release, a fresh 0x78/0x00/0xAF transfer -> RX 0xAF DC=0.
